// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU:
//   - 5-bit opcode encodings (OP_*)
//   - FSM state encoding (state_t: S_IDLE, S_ITER, S_FIX)
//   - is_multicycle(): true for opcodes that run on the iterative core
// Build option: ALU_DIV_EN -- when defined, DIV is an iterative operation;
// when undefined, DIV is treated as an unsupported opcode.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b01100;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b00001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [4:0] op);
`ifdef ALU_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// alu_muldiv_iter
// Unsigned iterative core: shift-add multiply or restoring divide, one bit
// per step. Operands are magnitudes; signs are handled by the caller.
// Build option: ALU_DIV_EN -- the restoring-divide step is only built when
// this macro is defined.
// Ports:
//   clock_i    clock
//   clear_i    synchronous active-high reset
//   load_i     capture operands and the operation kind, initialise acc
//   step_i     perform one iteration
//   is_div_i   operation kind captured on load (1 = divide)
//   a_mag_i    |A| (multiplier / dividend)
//   b_mag_i    |B| (multiplicand / divisor)
//   acc_o      2*WIDTH accumulator: product, or {remainder, quotient}
// ---------------------------------------------------------------------------
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clock_i,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 is_div_i,
    input  logic [WIDTH-1:0]     a_mag_i,
    input  logic [WIDTH-1:0]     b_mag_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   opb_q;
    logic               is_div_q;
    logic [WIDTH:0]     mul_sum;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]     div_hi;
    logic [WIDTH:0]     div_diff;
`endif

    always_comb begin
        acc_d   = acc_q;
        // Multiply: the low half holds the not-yet-consumed multiplier bits;
        // add the multiplicand into the high half when the current bit is set,
        // then shift the whole accumulator right (carry enters at the top).
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
`ifdef ALU_DIV_EN
        // Divide: shift {rem, dividend} left by one, try subtracting the
        // divisor from the partial remainder. One extra bit is needed since
        // the shifted remainder can reach 2*divisor-1.
        div_hi   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_hi - {1'b0, opb_q};
`endif
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, a_mag_i};
        end else if (step_i) begin
            if (is_div_q) begin
`ifdef ALU_DIV_EN
                if (!div_diff[WIDTH]) begin
                    acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {div_hi[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
`endif
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            if (load_i) begin
                opb_q    <= b_mag_i;
                is_div_q <= is_div_i;
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Multi-cycle integer ALU. Logic/add/sub/shift/rotate complete in one cycle;
// signed MUL (and DIV when built) run on an iterative core for WIDTH steps
// followed by a sign-fix cycle, behind a start/busy/done handshake.
// Build option: ALU_DIV_EN -- define to build the divider; otherwise DIV is
// reported as an unsupported opcode.
// Ports:
//   clock_i       clock
//   clear_i       synchronous active-high reset (wins over start_i)
//   start_i       operation request, accepted only while not busy
//   opcode_i      operation select (sampled on accept)
//   a_i, b_i      operands (sampled on accept)
//   busy_o        iterative operation in flight
//   done_o        one-cycle pulse, result_o valid
//   result_o      2*WIDTH registered result, held until next completion
//   div_zero_o    sticky: last accepted DIV had b=0
//   illegal_op_o  sticky: last accepted opcode unsupported
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clock_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [4:0]           opcode_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 div_zero_o,
    output logic                 illegal_op_o
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state_q;
    logic [SHW-1:0]     count_q;
    logic               done_q;
    logic [2*WIDTH-1:0] result_q;
    logic               div_zero_q;
    logic               illegal_q;
    logic               is_div_q;
    logic               neg_lo_q;   // product sign (MUL) or quotient sign (DIV)
    logic               neg_hi_q;   // remainder sign (DIV), follows A

    logic [WIDTH-1:0]   sc_result;
    logic               sc_legal;
    logic               big_shift;
    logic [SHW-1:0]     shamt;
    logic [SHW:0]       inv_amt;
    logic               div_by_zero;
    logic               multi;
    logic               core_load;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] core_acc;
    logic [WIDTH-1:0]   quot_s;
    logic [WIDTH-1:0]   rem_s;
    logic [2*WIDTH-1:0] fix_result;

    // -----------------------------------------------------------------------
    // Single-cycle datapath
    // -----------------------------------------------------------------------
    assign shamt     = b_i[SHW-1:0];
    assign big_shift = |b_i[WIDTH-1:SHW];
    // Complementary shift for rotates; amt=0 gives a shift by WIDTH, i.e. 0.
    assign inv_amt   = (SHW+1)'(WIDTH) - {1'b0, shamt};

    always_comb begin
        sc_result = '0;
        sc_legal  = 1'b1;
        case (opcode_i)
            OP_ADD:  sc_result = a_i + b_i;
            OP_SUB:  sc_result = a_i - b_i;
            OP_AND:  sc_result = a_i & b_i;
            OP_OR:   sc_result = a_i | b_i;
            OP_NOT:  sc_result = ~a_i;
            OP_NEG:  sc_result = -a_i;
            OP_SHL:  sc_result = big_shift ? '0 : (a_i << shamt);
            OP_SHR:  sc_result = big_shift ? '0 : (a_i >> shamt);
            OP_SHRA: sc_result = big_shift ? {WIDTH{a_i[WIDTH-1]}}
                                           : WIDTH'($signed(a_i) >>> shamt);
            OP_ROL:  sc_result = (a_i << shamt) | (a_i >> inv_amt);
            OP_ROR:  sc_result = (a_i >> shamt) | (a_i << inv_amt);
            default: sc_legal  = 1'b0;
        endcase
    end

`ifdef ALU_DIV_EN
    assign div_by_zero = (opcode_i == OP_DIV) && (b_i == '0);
`else
    assign div_by_zero = 1'b0;
`endif

    assign multi     = is_multicycle(opcode_i);
    assign core_load = (state_q == S_IDLE) && start_i && multi && !div_by_zero;
    assign a_mag     = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag     = b_i[WIDTH-1] ? -b_i : b_i;

    // -----------------------------------------------------------------------
    // Iterative core
    // -----------------------------------------------------------------------
    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_core (
        .clock_i  (clock_i),
        .clear_i  (clear_i),
        .load_i   (core_load),
        .step_i   (state_q == S_ITER),
        .is_div_i (opcode_i == OP_DIV),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .acc_o    (core_acc)
    );

    // Sign restoration applied in FIX.
    always_comb begin
        quot_s = neg_lo_q ? -core_acc[WIDTH-1:0]       : core_acc[WIDTH-1:0];
        rem_s  = neg_hi_q ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            fix_result = {rem_s, quot_s};
        end else begin
            fix_result = neg_lo_q ? -core_acc : core_acc;
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        // Flags are sticky only until the next accept.
                        div_zero_q <= 1'b0;
                        illegal_q  <= 1'b0;
                        if (div_by_zero) begin
                            result_q   <= {a_i, {WIDTH{1'b1}}};
                            div_zero_q <= 1'b1;
                            done_q     <= 1'b1;
                        end else if (multi) begin
                            state_q  <= S_ITER;
                            count_q  <= '0;
                            is_div_q <= (opcode_i == OP_DIV);
                            neg_lo_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                            neg_hi_q <= a_i[WIDTH-1];
                        end else begin
                            result_q  <= {{WIDTH{1'b0}}, sc_result};
                            illegal_q <= !sc_legal;
                            done_q    <= 1'b1;
                        end
                    end
                end
                S_ITER: begin
                    count_q <= count_q + SHW'(1);
                    if (count_q == SHW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= fix_result;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign result_o     = result_q;
    assign div_zero_o   = div_zero_q;
    assign illegal_op_o = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int W     = 32;
    localparam int LAT_M = W + 1;   // edges from accept to done for MUL/DIV

    localparam logic [4:0] T_ADD  = 5'b01100;
    localparam logic [4:0] T_SUB  = 5'b00100;
    localparam logic [4:0] T_AND  = 5'b01010;
    localparam logic [4:0] T_OR   = 5'b01011;
    localparam logic [4:0] T_NOT  = 5'b10010;
    localparam logic [4:0] T_NEG  = 5'b10001;
    localparam logic [4:0] T_SHL  = 5'b00111;
    localparam logic [4:0] T_SHR  = 5'b00101;
    localparam logic [4:0] T_SHRA = 5'b00110;
    localparam logic [4:0] T_ROL  = 5'b01001;
    localparam logic [4:0] T_ROR  = 5'b01000;
    localparam logic [4:0] T_MUL  = 5'b01111;
    localparam logic [4:0] T_DIV  = 5'b00001;
    localparam logic [4:0] T_BAD  = 5'b11111;

    logic             clock = 1'b0;
    logic             clear;
    logic             start;
    logic [4:0]       opcode;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   result;
    logic             div_zero;
    logic             illegal_op;

    typedef struct {
        string        tag;
        logic [63:0]  res;
        logic         dz;
        logic         ill;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    alu_seq #(
        .WIDTH (W)
    ) dut (
        .clock_i      (clock),
        .clear_i      (clear),
        .start_i      (start),
        .opcode_i     (opcode),
        .a_i          (a),
        .b_i          (b),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .div_zero_o   (div_zero),
        .illegal_op_o (illegal_op)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic push_exp(input string tag, input logic [63:0] res, input logic dz,
                            input logic ill, input int lat);
        exp_t e;
        e.tag = tag;
        e.res = res;
        e.dz  = dz;
        e.ill = ill;
        e.lat = lat;
        sb.push_back(e);
    endtask

    // Issue one op, wait (bounded) for done, compare against the scoreboard.
    // inj >= 0: assert a competing ADD start that many edges after accept.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [63:0] res, input logic dz,
                          input logic ill, input int lat, input int inj);
        exp_t e;
        int   edges;
        int   busy_seen;
        push_exp(tag, res, dz, ill, lat);
        @(negedge clock);
        opcode = op;
        a      = va;
        b      = vb;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        edges     = 0;
        busy_seen = 0;
        while (!done && edges < 200) begin
            if (busy) busy_seen++;
            if (edges == inj) begin
                opcode = T_ADD;
                a      = 32'd1;
                b      = 32'd1;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            edges++;
        end
        start = 1'b0;
        e = sb.pop_front();
        check({e.tag, "_done"}, {63'd0, done}, 64'd1);
        check({e.tag, "_res"}, result, e.res);
        check({e.tag, "_dz"}, {63'd0, div_zero}, {63'd0, e.dz});
        check({e.tag, "_ill"}, {63'd0, illegal_op}, {63'd0, e.ill});
        check({e.tag, "_lat"}, 64'(edges), 64'(e.lat));
        check({e.tag, "_busycyc"}, 64'(busy_seen), 64'(e.lat));
        check({e.tag, "_busyend"}, {63'd0, busy}, 64'd0);
        $display("txn %-10s op=%b a=%h b=%h result=%h dz=%0b ill=%0b edges=%0d",
                 e.tag, op, va, vb, result, div_zero, illegal_op, edges);
        @(posedge clock);
        #1;
        check({e.tag, "_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int edges;
        int dones;
        exp_t e;

        clear  = 1'b1;
        start  = 1'b0;
        opcode = '0;
        a      = '0;
        b      = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_dz", {63'd0, div_zero}, 64'd0);
        check("rst_ill", {63'd0, illegal_op}, 64'd0);
        @(negedge clock);
        clear = 1'b0;

        // Single-cycle operations
        run_op("add",     T_ADD,  32'd7,          32'd5,          64'h0000_0000_0000_000C, 0, 0, 0, -1);
        run_op("sub",     T_SUB,  32'd5,          32'd7,          64'h0000_0000_FFFF_FFFE, 0, 0, 0, -1);
        run_op("and",     T_AND,  32'hF0F0_1234,  32'h0FF0_FF00,  64'h0000_0000_00F0_1200, 0, 0, 0, -1);
        run_op("or",      T_OR,   32'hF0F0_1234,  32'h0FF0_FF00,  64'h0000_0000_FFF0_FF34, 0, 0, 0, -1);
        run_op("not",     T_NOT,  32'h0000_FFFF,  32'd0,          64'h0000_0000_FFFF_0000, 0, 0, 0, -1);
        run_op("neg",     T_NEG,  32'd1,          32'd0,          64'h0000_0000_FFFF_FFFF, 0, 0, 0, -1);
        run_op("shl31",   T_SHL,  32'd1,          32'd31,         64'h0000_0000_8000_0000, 0, 0, 0, -1);
        run_op("shl32",   T_SHL,  32'd1,          32'd32,         64'h0,                   0, 0, 0, -1);
        run_op("shr31",   T_SHR,  32'h8000_0000,  32'd31,         64'h1,                   0, 0, 0, -1);
        run_op("shrbig",  T_SHR,  32'hFFFF_FFFF,  32'h8000_0000,  64'h0,                   0, 0, 0, -1);
        run_op("shra4",   T_SHRA, 32'h8000_0000,  32'd4,          64'h0000_0000_F800_0000, 0, 0, 0, -1);
        run_op("shra40",  T_SHRA, 32'h8000_0000,  32'd40,         64'h0000_0000_FFFF_FFFF, 0, 0, 0, -1);
        run_op("ror33",   T_ROR,  32'h0000_0001,  32'd33,         64'h0000_0000_8000_0000, 0, 0, 0, -1);
        run_op("rol4",    T_ROL,  32'h8000_0001,  32'd4,          64'h0000_0000_0000_0018, 0, 0, 0, -1);

        // Unsupported opcode, then the next accept clears the flag
        run_op("bad",     T_BAD,  32'h1234,       32'h5678,       64'h0,                   0, 1, 0, -1);
        run_op("add_ok",  T_ADD,  32'd1,          32'd2,          64'h3,                   0, 0, 0, -1);

        // Iterative multiply
        run_op("mul",     T_MUL,  32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1, 0, 0, LAT_M, -1);
        run_op("mulmin",  T_MUL,  32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 0, 0, LAT_M, -1);

        // Divide (built only with ALU_DIV_EN; otherwise reported as unsupported)
`ifdef ALU_DIV_EN
        run_op("div",     T_DIV,  32'hFFFF_FFF9,  32'd2,          64'hFFFF_FFFF_FFFF_FFFD, 0, 0, LAT_M, -1);
        run_op("div_neg", T_DIV,  32'd100,        32'hFFFF_FFF9,  64'h0000_0002_FFFF_FFF2, 0, 0, LAT_M, -1);
        run_op("div0",    T_DIV,  32'd9,          32'd0,          64'h0000_0009_FFFF_FFFF, 1, 0, 0, -1);
`else
        run_op("div",     T_DIV,  32'hFFFF_FFF9,  32'd2,          64'h0,                   0, 1, 0, -1);
        run_op("div0",    T_DIV,  32'd9,          32'd0,          64'h0,                   0, 1, 0, -1);
`endif
        run_op("after_dv", T_AND, 32'hFF,         32'h0F,         64'h0F,                  0, 0, 0, -1);

        // start while busy is ignored
        run_op("mul_inj", T_MUL,  32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1, 0, 0, LAT_M, 5);

        // clear in the middle of a multiply discards it
        @(negedge clock);
        opcode = T_MUL;
        a      = 32'd1234;
        b      = 32'd5678;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check("clr_pre_busy", {63'd0, busy}, 64'd1);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        check("clr_busy", {63'd0, busy}, 64'd0);
        check("clr_done", {63'd0, done}, 64'd0);
        check("clr_result", result, 64'd0);
        dones = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) dones++;
        end
        check("clr_nodone", 64'(dones), 64'd0);
        $display("txn clear_mid  busy=%0b result=%h dones_after=%0d", busy, result, dones);

        // Back-to-back: next op accepted in the cycle done is high
        push_exp("b2b_mul", 64'h0000_0000_0000_002A, 0, 0, LAT_M);
        @(negedge clock);
        opcode = T_MUL;
        a      = 32'hFFFF_FFF9;
        b      = 32'hFFFF_FFFA;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        edges = 0;
        while (!done && edges < 200) begin
            @(posedge clock);
            #1;
            edges++;
        end
        e = sb.pop_front();
        check({e.tag, "_res"}, result, e.res);
        check({e.tag, "_lat"}, 64'(edges), 64'(e.lat));
        $display("txn %-10s result=%h edges=%0d", e.tag, result, edges);
        push_exp("b2b_add", 64'h5, 0, 0, 0);
        opcode = T_ADD;
        a      = 32'd2;
        b      = 32'd3;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        e = sb.pop_front();
        check({e.tag, "_done"}, {63'd0, done}, 64'd1);
        check({e.tag, "_res"}, result, e.res);
        $display("txn %-10s result=%h done=%0b", e.tag, result, done);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
